// File: rtl/management_bridge.sv
// Management bridge: turns QSPI frames (2 address bytes + data bytes) into
// register-interface reads and writes, streaming read data back to the PHY.
module management_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_data_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_data_ready,
    output logic        tx_data_valid,
    output logic [7:0]  tx_data,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic        rd_valid,
    input  logic [7:0]  rd_data,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_timeout
);

    // Handshake: every strobe (start, rx_data_valid, tx_data_ready, rd_valid,
    // rd_en, wr_en, tx_data_valid, rd_timeout) is a one-cycle event; data rides
    // with its strobe and there is no back-pressure on any of them.
    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        WRITE,
        READ_WAIT,
        READ_HOLD
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'd254;

    state_t      state, state_nxt;
    logic [14:0] addr, addr_nxt;
    logic        dir, dir_nxt;
    logic        rd_pending, pending_nxt;
    logic        outstanding, outstanding_nxt;
    logic [7:0]  tmo_cnt, tmo_cnt_nxt;
    logic        rd_en_nxt, wr_en_nxt, tx_valid_nxt, rd_timeout_nxt;
    logic [15:0] rd_addr_nxt, wr_addr_nxt;
    logic [7:0]  wr_data_nxt, tx_data_nxt;
    logic        issue_rd;
    logic [14:0] issue_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            dir           <= 1'b0;
            rd_pending    <= 1'b0;
            outstanding   <= 1'b0;
            tmo_cnt       <= '0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            rd_timeout    <= 1'b0;
        end else begin
            state         <= state_nxt;
            addr          <= addr_nxt;
            dir           <= dir_nxt;
            rd_pending    <= pending_nxt;
            outstanding   <= outstanding_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            rd_en         <= rd_en_nxt;
            rd_addr       <= rd_addr_nxt;
            wr_en         <= wr_en_nxt;
            wr_addr       <= wr_addr_nxt;
            wr_data       <= wr_data_nxt;
            tx_data       <= tx_data_nxt;
            tx_data_valid <= tx_valid_nxt;
            rd_timeout    <= rd_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        addr_nxt        = addr;
        dir_nxt         = dir;
        pending_nxt     = rd_pending;
        outstanding_nxt = outstanding;
        tmo_cnt_nxt     = tmo_cnt;
        rd_en_nxt       = 1'b0;
        rd_addr_nxt     = rd_addr;
        wr_en_nxt       = 1'b0;
        wr_addr_nxt     = wr_addr;
        wr_data_nxt     = wr_data;
        tx_data_nxt     = tx_data;
        tx_valid_nxt    = 1'b0;
        rd_timeout_nxt  = 1'b0;
        issue_rd        = 1'b0;
        issue_addr      = addr;

        // Any completion retires the single outstanding read, stale or not.
        if (rd_valid) begin
            outstanding_nxt = 1'b0;
        end

        if (start) begin
            state_nxt   = ADDR_HI;
            pending_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                end
                ADDR_HI: begin
                    if (rx_data_valid) begin
                        dir_nxt         = rx_data[7];
                        addr_nxt[14:8]  = rx_data[6:0];
                        state_nxt       = ADDR_LO;
                    end
                end
                ADDR_LO: begin
                    if (rx_data_valid) begin
                        addr_nxt[7:0] = rx_data;
                        if (dir) begin
                            issue_rd   = 1'b1;
                            issue_addr = {addr[14:8], rx_data};
                            state_nxt  = READ_WAIT;
                        end else begin
                            state_nxt = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (rx_data_valid) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = {1'b0, addr};
                        wr_data_nxt = rx_data;
                        addr_nxt    = addr + 15'd1;
                    end
                end
                READ_WAIT: begin
                    // A deferred read waits here until the abandoned one retires.
                    if (rd_pending) begin
                        if (!outstanding) begin
                            issue_rd = 1'b1;
                        end
                    end else if (rd_valid) begin
                        tx_data_nxt  = rd_data;
                        tx_valid_nxt = 1'b1;
                        state_nxt    = READ_HOLD;
                    end else if (tmo_cnt == TIMEOUT_LAST) begin
                        tx_data_nxt    = 8'h00;
                        tx_valid_nxt   = 1'b1;
                        rd_timeout_nxt = 1'b1;
                        state_nxt      = READ_HOLD;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 8'd1;
                    end
                end
                READ_HOLD: begin
                    if (tx_data_ready) begin
                        addr_nxt   = addr + 15'd1;
                        issue_rd   = 1'b1;
                        issue_addr = addr + 15'd1;
                        state_nxt  = READ_WAIT;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        if (issue_rd) begin
            if (outstanding) begin
                pending_nxt = 1'b1;
            end else begin
                rd_en_nxt       = 1'b1;
                rd_addr_nxt     = {1'b0, issue_addr};
                outstanding_nxt = 1'b1;
                tmo_cnt_nxt     = '0;
                pending_nxt     = 1'b0;
            end
        end
    end

endmodule
